// File: rtl/mips_core_pkg.sv
// Shared core types: arbitration policy and search direction used by the
// request arbiters.
package mips_core_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED_LOW,
    ARB_FIXED_HIGH,
    ARB_ROUND_ROBIN
  } arb_mode_t;

  typedef enum logic {
    PICK_ASC,
    PICK_DESC
  } pick_dir_t;

endpackage

// File: rtl/masked_pick.sv
// Combinational picker: first set bit at or above start_i, falling back to
// the whole vector, in the requested direction.
module masked_pick
  import mips_core_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [IDX_W-1:0] start_i,
  input  pick_dir_t        dir_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Returns {found, index}; ascending yields the lowest set bit, descending the highest.
  function automatic logic [IDX_W:0] first_set(input logic [WIDTH-1:0] v,
                                               input pick_dir_t        dir);
    logic [IDX_W:0] res;
    res = '0;
    if (dir == PICK_ASC) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) res = {1'b1, IDX_W'(i)};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  logic [WIDTH-1:0] masked;
  logic             hi_found, all_found;
  logic [IDX_W-1:0] hi_idx, all_idx;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      masked[i] = vec_i[i] && (i >= int'(start_i));
    end
  end

  assign {hi_found, hi_idx}   = first_set(masked, dir_i);
  assign {all_found, all_idx} = first_set(vec_i, dir_i);

  assign found_o = hi_found | all_found;
  assign idx_o   = hi_found ? hi_idx : all_idx;

endmodule

// File: rtl/priority_arbiter.sv
// Registered request arbiter with valid/ready grant handshake; fixed-low,
// fixed-high or round-robin selection chosen by MODE.
module priority_arbiter
  import mips_core_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 32,
  parameter  arb_mode_t   MODE    = ARB_FIXED_HIGH,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               flush,
  input  logic               grant_ready,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant_onehot
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("priority_arbiter: NUM_REQ must be >= 2");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam bit               IS_RR    = (MODE == ARB_ROUND_ROBIN);

  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] onehot_q, onehot_d;

  logic               accept, load;
  logic [NUM_REQ-1:0] req_eff;
  logic [IDX_W-1:0]   start_idx, pick_idx;
  logic               pick_found;
  pick_dir_t          pick_dir;

  assign accept = valid_q & grant_ready;
  assign load   = ~valid_q | accept;

  // The grant leaving this cycle must not be re-picked from a still-high request.
  always_comb begin
    req_eff = req;
    if (accept) req_eff[idx_q] = 1'b0;
  end

  assign start_idx = IS_RR ? ptr_q : '0;
  assign pick_dir  = (MODE == ARB_FIXED_HIGH) ? PICK_DESC : PICK_ASC;

  masked_pick #(
    .WIDTH (NUM_REQ)
  ) u_pick (
    .vec_i   (req_eff),
    .start_i (start_idx),
    .dir_i   (pick_dir),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no branch can infer a latch.
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    if (flush) begin
      valid_d  = 1'b0;
      onehot_d = '0;
    end else if (load) begin
      valid_d  = pick_found;
      onehot_d = '0;
      if (pick_found) begin
        idx_d              = pick_idx;
        onehot_d[pick_idx] = 1'b1;
      end
      if (accept && IS_RR) begin
        ptr_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;

endmodule
